// File: rtl/hwag_wheel_pkg.sv
// Shared wheel constants, run state encoding and period helper for the crank
// wheel generator and the hwag capture side.
package hwag_wheel_pkg;

    localparam int TICK_W      = 18;
    localparam int TOOTH_W     = 6;
    localparam int PERIOD_W    = 16;
    localparam int DEF_TEETH   = 60;
    localparam int DEF_MISSING = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wheel_state_t;

    // A period below 2 would leave no low phase before the rising edge.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
    endfunction

endpackage

// File: rtl/crank_slot_timer.sv
// Tooth slot timer: counts ticks within a slot, stretches the gap slot and
// flags the cycle before the rising edge and the last cycle of the slot.
module crank_slot_timer
    import hwag_wheel_pkg::*;
#(
    parameter int MISSING = DEF_MISSING
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                active,
    input  logic                gap,
    input  logic [PERIOD_W-1:0] period,
    output logic                slot_end,
    output logic                rise
);

    logic [PERIOD_W-1:0] period_q;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   p_ext;
    logic [TICK_W-1:0]   slot_len;
    logic [TICK_W-1:0]   rise_pt;

    // 18-bit arithmetic keeps (MISSING+1)*65535 from truncating.
    assign p_ext    = TICK_W'(period_q);
    assign slot_len = gap ? p_ext * TICK_W'(MISSING + 1) : p_ext;
    assign rise_pt  = slot_len - p_ext + (p_ext >> 1);

    assign slot_end = active && (tick == slot_len - TICK_W'(1));
    assign rise     = active && (tick == rise_pt - TICK_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= '0;
            period_q <= PERIOD_W'(2);
        end else if (load) begin
            tick     <= '0;
            period_q <= clamp_period(period);
        end else if (active) begin
            if (slot_end) begin
                tick     <= '0;
                period_q <= clamp_period(period);
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end else begin
            tick <= '0;
        end
    end

endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 style crank/cam trigger-wheel generator: tooth train with a missing
// tooth gap, cam phase on alternate revolutions and a revolution strobe.
module crank_wheel_gen
    import hwag_wheel_pkg::*;
#(
    parameter int TEETH         = DEF_TEETH,
    parameter int MISSING       = DEF_MISSING,
    parameter int START_TOOTH   = 45,
    parameter int PHASE_TOOTH   = 30,
    parameter int CAM_ON_TOOTH  = 4,
    parameter int CAM_OFF_TOOTH = 54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] period,
    output logic        cap_out,
    output logic        cam_out,
    output logic [5:0]  tooth_num,
    output logic        gap_slot,
    output logic        rev_strobe
);

    localparam int                 N         = TEETH - MISSING;
    localparam logic [TOOTH_W-1:0] LAST      = TOOTH_W'(N - 1);
    localparam logic [TOOTH_W-1:0] START     = TOOTH_W'(START_TOOTH);
    localparam logic [TOOTH_W-1:0] PHASE_T   = TOOTH_W'(PHASE_TOOTH);
    localparam logic [TOOTH_W-1:0] CAM_ON_T  = TOOTH_W'(CAM_ON_TOOTH);
    localparam logic [TOOTH_W-1:0] CAM_OFF_T = TOOTH_W'(CAM_OFF_TOOTH);
    localparam logic               START_GAP = (START == LAST);

    wheel_state_t       state;
    wheel_state_t       state_next;
    logic               load;
    logic               active;
    logic               slot_end;
    logic               rise;
    logic               phase;
    logic [TOOTH_W-1:0] tooth_next;

    assign load       = (state == IDLE) && en;
    assign active     = (state == RUN) && en;
    assign tooth_next = (tooth_num == LAST) ? '0 : tooth_num + TOOTH_W'(1);

    crank_slot_timer #(
        .MISSING (MISSING)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .active   (active),
        .gap      (gap_slot),
        .period   (period),
        .slot_end (slot_end),
        .rise     (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dropping en wins over a coinciding slot boundary: no advance, no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_out    <= 1'b0;
            cam_out    <= 1'b1;
            phase      <= 1'b0;
            tooth_num  <= START;
            gap_slot   <= 1'b0;
            rev_strobe <= 1'b0;
        end else begin
            rev_strobe <= 1'b0;
            if (!active) begin
                cap_out   <= 1'b0;
                tooth_num <= START;
                gap_slot  <= START_GAP;
            end else if (slot_end) begin
                cap_out    <= 1'b0;
                tooth_num  <= tooth_next;
                gap_slot   <= (tooth_next == LAST);
                rev_strobe <= (tooth_num == LAST);
                // Cam decisions use the phase value held before any toggle.
                if (tooth_next == PHASE_T)
                    phase <= ~phase;
                if (phase && (tooth_next == CAM_OFF_T))
                    cam_out <= 1'b0;
                if (phase && (tooth_next == CAM_ON_T))
                    cam_out <= 1'b1;
            end else if (rise) begin
                cap_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: expectations are queued with the cycle
// at which they become due and compared at the following falling edges.
module tb_crank_wheel_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic        cap_out;
    logic        cam_out;
    logic [5:0]  tooth_num;
    logic        gap_slot;
    logic        rev_strobe;

    crank_wheel_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period     (period),
        .cap_out    (cap_out),
        .cam_out    (cam_out),
        .tooth_num  (tooth_num),
        .gap_slot   (gap_slot),
        .rev_strobe (rev_strobe)
    );

    typedef struct {
        int         cyc;
        string      tag;
        logic [9:0] exp;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   e0, e2, e3, e4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ov(input bit cap, input bit cam, input int tooth,
                                      input bit gap, input bit rev);
        logic [5:0] t;
        t = 6'(tooth);
        return {cap, cam, t, gap, rev};
    endfunction

    function automatic logic [9:0] obs();
        return {cap_out, cam_out, tooth_num, gap_slot, rev_strobe};
    endfunction

    task automatic expect_at(input int c, input string tag, input logic [9:0] v);
        ent_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Outputs are read on the falling edge, away from the active edge.
    always @(negedge clk) begin
        ent_t   e;
        logic [9:0] o;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            o = obs();
            n_cmp++;
            assert (o === e.exp) else begin
                n_bad++;
                $error("FAIL %s cyc=%0d observed={cap,cam,tooth,gap,rev}=%b,%b,%0d,%b,%b expected=%b,%b,%0d,%b,%b",
                       e.tag, cyc, o[9], o[8], o[7:2], o[1], o[0],
                       e.exp[9], e.exp[8], e.exp[7:2], e.exp[1], e.exp[0]);
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        period = 16'd8;
        @(negedge clk);
        expect_at(cyc + 1, "reset", ov(0, 1, 45, 0, 0));
        wait_cyc(cyc + 1);
        rst = 1'b0;
        expect_at(cyc + 1, "idle", ov(0, 1, 45, 0, 0));
        wait_cyc(cyc + 1);

        // Run at period 8: entry edge is e0.
        en = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 24; k++)
            expect_at(e0 + k, "run8", ov((k % 8) >= 4, 1, 45 + k / 8, 0, 0));
        expect_at(e0 + 95,  "pre_gap",    ov(1, 1, 56, 0, 0));
        expect_at(e0 + 96,  "gap_start",  ov(0, 1, 57, 1, 0));
        expect_at(e0 + 115, "gap_low",    ov(0, 1, 57, 1, 0));
        expect_at(e0 + 116, "gap_rise",   ov(1, 1, 57, 1, 0));
        expect_at(e0 + 119, "gap_end",    ov(1, 1, 57, 1, 0));
        expect_at(e0 + 120, "wrap1",      ov(0, 1, 0, 0, 1));
        expect_at(e0 + 121, "wrap1_once", ov(0, 1, 0, 0, 0));
        expect_at(e0 + 551, "cam_pre_off", ov(1, 1, 53, 0, 0));
        expect_at(e0 + 552, "cam_off",    ov(0, 0, 54, 0, 0));
        expect_at(e0 + 600, "wrap2",      ov(0, 0, 0, 0, 1));
        expect_at(e0 + 631, "cam_pre_on", ov(1, 0, 3, 0, 0));
        expect_at(e0 + 632, "cam_on",     ov(0, 1, 4, 0, 0));
        expect_at(e0 + 1032, "cam_hold",  ov(0, 1, 54, 0, 0));

        // Period change mid-slot only applies from the next boundary.
        expect_at(e0 + 1047, "old_slot_end", ov(1, 1, 55, 0, 0));
        expect_at(e0 + 1048, "p20_start",    ov(0, 1, 56, 0, 0));
        expect_at(e0 + 1057, "p20_low",      ov(0, 1, 56, 0, 0));
        expect_at(e0 + 1058, "p20_rise",     ov(1, 1, 56, 0, 0));
        expect_at(e0 + 1067, "p20_end",      ov(1, 1, 56, 0, 0));
        expect_at(e0 + 1068, "p20_gap",      ov(0, 1, 57, 1, 0));
        wait_cyc(e0 + 1043);
        period = 16'd20;

        // Drop en at tick 5 of the gap slot.
        expect_at(e0 + 1073, "pre_drop",  ov(0, 1, 57, 1, 0));
        expect_at(e0 + 1074, "dropped",   ov(0, 1, 45, 0, 0));
        expect_at(e0 + 1080, "idle_hold", ov(0, 1, 45, 0, 0));
        wait_cyc(e0 + 1073);
        en = 1'b0;
        wait_cyc(e0 + 1080);
        en = 1'b1;
        e2 = cyc + 1;
        expect_at(e2,      "restart",     ov(0, 1, 45, 0, 0));
        expect_at(e2 + 9,  "restart_low", ov(0, 1, 45, 0, 0));
        expect_at(e2 + 10, "restart_hi",  ov(1, 1, 45, 0, 0));
        expect_at(e2 + 19, "restart_end", ov(1, 1, 45, 0, 0));
        expect_at(e2 + 20, "restart_t46", ov(0, 1, 46, 0, 0));
        expect_at(e2 + 39, "bnd_pre",     ov(1, 1, 46, 0, 0));
        expect_at(e2 + 40, "bnd_idle",    ov(0, 1, 45, 0, 0));

        // en falls exactly on a slot boundary.
        wait_cyc(e2 + 39);
        en = 1'b0;

        // period 0 and 1 behave as period 2.
        wait_cyc(e2 + 41);
        period = 16'd0;
        en     = 1'b1;
        e3 = cyc + 1;
        expect_at(e3,     "p0_t0", ov(0, 1, 45, 0, 0));
        expect_at(e3 + 1, "p0_t1", ov(1, 1, 45, 0, 0));
        expect_at(e3 + 2, "p0_t2", ov(0, 1, 46, 0, 0));
        expect_at(e3 + 3, "p0_t3", ov(1, 1, 46, 0, 0));
        wait_cyc(e3 + 3);
        period = 16'd1;
        expect_at(e3 + 4,   "p1_t0",    ov(0, 1, 47, 0, 0));
        expect_at(e3 + 5,   "p1_t1",    ov(1, 1, 47, 0, 0));
        expect_at(e3 + 24,  "p1_gap",   ov(0, 1, 57, 1, 0));
        expect_at(e3 + 28,  "p1_gaplo", ov(0, 1, 57, 1, 0));
        expect_at(e3 + 29,  "p1_gaphi", ov(1, 1, 57, 1, 0));
        expect_at(e3 + 30,  "p1_wrap",  ov(0, 1, 0, 0, 1));
        expect_at(e3 + 138, "p1_camoff", ov(0, 0, 54, 0, 0));
        expect_at(e3 + 146, "pre_rst",  ov(0, 0, 57, 1, 0));
        wait_cyc(e3 + 146);

        // Asynchronous reset in the middle of the gap slot, between edges.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        assert (obs() === ov(0, 1, 45, 0, 0)) else begin
            n_bad++;
            $error("FAIL async_rst observed=%b expected=%b", obs(), ov(0, 1, 45, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        e4 = cyc + 1;
        expect_at(e4,     "post_rst_entry", ov(0, 1, 45, 0, 0));
        expect_at(e4 + 1, "post_rst_rise",  ov(1, 1, 45, 0, 0));
        wait_cyc(e4 + 3);

        n_cmp++;
        assert (q.size() == 0) else begin
            n_bad++;
            $error("FAIL queue_drain observed=%0d pending expected=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthesizable crank/cam trigger-wheel generator; the transmit end of the hwag capture input (cap_in) and cam input.
- Produces a 60-2 style tooth train with a missing-tooth gap, a cam phase signal on alternate revolutions, and per-revolution strobes.
- Used as an on-chip stimulus source for bring-up and the hwag self-test loop; replaces behavioural wheel models in benches.

Parameters:
- TEETH, 60, nominal tooth positions per revolution.
- MISSING, 2, missing teeth in gap (1..3).
- START_TOOTH, 45, tooth index loaded on run start.
- PHASE_TOOTH, 30, entering this tooth toggles cam phase.
- CAM_ON_TOOTH, 4, entering this tooth with phase=1 drives cam_out=1.
- CAM_OFF_TOOTH, 54, entering this tooth with phase=1 drives cam_out=0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; low forces idle
- period  in  16  tooth slot length in clk cycles
- cap_out  out  1  VR-equivalent tooth signal to hwag cap_in
- cam_out  out  1  cam phase signal
- tooth_num  out  6  current tooth index, 0..TEETH-MISSING-1
- gap_slot  out  1  high while in the long (gap) slot
- rev_strobe  out  1  one-cycle pulse on tooth wrap to 0

Behaviour:
- Reset: cap_out=0, cam_out=1, phase=0, tooth_num=START_TOOTH, gap_slot=0, rev_strobe=0, tick=0, state IDLE.
- Physical teeth N = TEETH-MISSING (58). Tooth N-1 is the gap slot.
- States: IDLE, RUN.
- IDLE: cap_out=0, tick=0, tooth=START_TOOTH; cam_out and phase hold.
- IDLE->RUN on the edge sampling en=1. That edge latches period_q = max(period,2), tick=0.
- RUN->IDLE on the edge sampling en=0, from any tick. cap_out=0 on that edge. No partial slot completes.
- Slot length L: period_q for normal slots, (MISSING+1)*period_q for the gap slot. Internal tick counter is 18 bits; the product must never truncate.
- Rise point R = L - period_q + (period_q>>1).
- cap_out is registered: 0 for ticks 0..R-1, 1 for ticks R..L-1. Normal slot with P=8: 4 low, 4 high.
- When tick==L-1, the next edge performs the slot boundary:
  - tick=0, cap_out=0.
  - tooth advances: N-1 -> 0 with rev_strobe=1 for that cycle; otherwise tooth+1.
  - period_q reloads from period.
  - gap_slot = (new tooth==N-1).
- The period input is sampled only at run start and at slot boundaries. Changes mid-slot have no effect until the next boundary.
- Cam updates take effect on the boundary edge, using the new tooth index:
  - new tooth==PHASE_TOOTH: phase toggles.
  - If phase (pre-toggle value) is 1 and new tooth==CAM_OFF_TOOTH: cam_out=0.
  - If phase is 1 and new tooth==CAM_ON_TOOTH: cam_out=1.
  - With phase=0, cam_out holds.
- Simultaneous en=0 with a slot boundary: IDLE wins. Tooth resets to START_TOOTH, no rev_strobe.
- rst mid-slot: all state returns to reset values immediately, asynchronously.
- period<2 clamps to 2, so R≥1 and cap_out always has a low phase.

Decomposition:
- Shared package hwag_wheel_pkg:
  - state enum (IDLE, RUN).
  - TICK_W=18, TOOTH_W=6.
  - Default wheel constants (60, 2) shared with hwag tooth-count registers.
- One natural sub-module, crank_slot_timer:
  - Holds tick, L, R and period_q.
  - Outputs slot_end and rise pulses.
- Tooth, cam and strobe logic stay in crank_wheel_gen.

Test Plan:
- Reset + en=1, period=8: first cap_out rise 4 cycles after the RUN entry edge; 8-cycle period, 50% duty. tooth_num steps 45,46,… every 8 cycles.
- Run to the gap slot (tooth 57), period=8: gap_slot=1, cap_out low 20 cycles then high 4 cycles. Next boundary gives tooth_num=0 and rev_strobe high exactly one cycle.
- Two full revolutions from reset (cam_out=1, phase=0):
  - phase toggles at tooth 30 each revolution.
  - In the revolution after the first toggle, cam_out falls on entering tooth 54.
  - cam_out rises on entering tooth 4 of the following revolution; held otherwise.
- Change period 8->20 at tick 3 of a slot: that slot still completes in 8 cycles. Next slot is 20 cycles, rise at tick 10.
- Drop en at tick 5 of a slot: cap_out=0 next edge, tooth_num=45, no rev_strobe. Re-assert en: run restarts from tooth 45, tick 0.
- period=0 and period=1: behave as period=2 (1 low, 1 high). Assert rst mid-gap: all outputs return to reset values without waiting for clk.
